// File: rtl/rob_commit_unit.sv
// In-order retirement from the ROB head: register writeback, store release,
// mispredict flush with redirect, and halt on exception.
module rob_commit_unit #(
   parameter int ROBsize      = 16,
   parameter int addrSize     = $clog2(ROBsize),
   parameter int FLUSH_CYCLES = 3
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                robValid_i,
   input  logic [addrSize:0]   head_i,
   input  logic [78:0]         commitReadData_i,
   output logic                updateHead_o,
   output logic                rfWriteEn_o,
   output logic [4:0]          rfWriteAddr_o,
   output logic [63:0]         rfWriteData_o,
   output logic [addrSize:0]   rfWriteTag_o,
   output logic                storeCommitValid_o,
   input  logic                storeCommitReady_i,
   output logic                flush_o,
   output logic [63:0]         redirectPc_o,
   output logic                halted_o,
   output logic [31:0]         commitCount_o
);

   typedef enum logic [1:0] {
      S_COMMIT,
      S_STORE_WAIT,
      S_FLUSH,
      S_HALT
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t       r_state;
   state_t       w_stateNxt;
   logic [3:0]   r_flushCnt;
   logic [3:0]   w_flushCntNxt;
   logic [31:0]  r_commitCount;
   logic [63:0]  r_redirectPc;
   logic         w_retire;
   logic         w_storeValid;

   logic         w_done;
   logic         w_regWrite;
   logic         w_isStore;
   logic         w_mispredict;
   logic         w_exception;
   logic [4:0]   w_destReg;
   logic [63:0]  w_value;
   logic [4:0]   w_unused_reserved;

   assign w_done            = commitReadData_i[78];
   assign w_regWrite        = commitReadData_i[77];
   assign w_isStore         = commitReadData_i[76];
   assign w_mispredict      = commitReadData_i[75];
   assign w_exception       = commitReadData_i[74];
   assign w_destReg         = commitReadData_i[73:69];
   assign w_unused_reserved = commitReadData_i[68:64];
   assign w_value           = commitReadData_i[63:0];

   // Next-state and retire decision
   always_comb begin
      w_stateNxt    = r_state;
      w_flushCntNxt = r_flushCnt;
      w_retire      = 1'b0;
      w_storeValid  = 1'b0;
      case (r_state)
         S_COMMIT: begin
            if (robValid_i && w_done) begin
               if (w_exception) begin
                  w_stateNxt = S_HALT;
               end else if (w_isStore) begin
                  w_storeValid = 1'b1;
                  if (storeCommitReady_i) w_retire = 1'b1;
                  else                    w_stateNxt = S_STORE_WAIT;
               end else begin
                  w_retire = 1'b1;
               end
            end
         end
         S_STORE_WAIT: begin
            // Valid is held until the store buffer accepts.
            w_storeValid = 1'b1;
            if (storeCommitReady_i && robValid_i) begin
               w_retire   = 1'b1;
               w_stateNxt = S_COMMIT;
            end
         end
         S_FLUSH: begin
            if (r_flushCnt == 4'd0) w_stateNxt = S_COMMIT;
            else                    w_flushCntNxt = r_flushCnt - 4'd1;
         end
         S_HALT: begin
            w_stateNxt = S_HALT;
         end
         default: begin
            w_stateNxt = S_COMMIT;
         end
      endcase
      if (w_retire && w_mispredict) begin
         w_stateNxt    = S_FLUSH;
         w_flushCntNxt = FLUSH_LOAD;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state       <= S_COMMIT;
         r_flushCnt    <= 4'd0;
         r_commitCount <= 32'd0;
         r_redirectPc  <= 64'd0;
      end else begin
         r_state    <= w_stateNxt;
         r_flushCnt <= w_flushCntNxt;
         if (w_retire) r_commitCount <= r_commitCount + 32'd1;
         if (w_retire && w_mispredict) r_redirectPc <= w_value;
      end
   end

   // A cycle with reset asserted never issues a retire or a store release.
   always_comb begin
      updateHead_o       = w_retire & reset_i;
      rfWriteEn_o        = w_retire & reset_i & w_regWrite;
      rfWriteAddr_o      = updateHead_o ? w_destReg : 5'd0;
      rfWriteData_o      = updateHead_o ? w_value : 64'd0;
      rfWriteTag_o       = updateHead_o ? head_i : '0;
      storeCommitValid_o = w_storeValid & reset_i;
      flush_o            = (r_state == S_FLUSH) & reset_i;
      halted_o           = (r_state == S_HALT) & reset_i;
      redirectPc_o       = r_redirectPc;
      commitCount_o      = r_commitCount;
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit with hand-computed expectations.
module tb_rob_commit_unit;

   localparam int ROBsize      = 16;
   localparam int addrSize     = 4;
   localparam int FLUSH_CYCLES = 3;

   logic                clk_i = 1'b0;
   logic                reset_i;
   logic                robValid_i;
   logic [addrSize:0]   head_i;
   logic [78:0]         commitReadData_i;
   logic                updateHead_o;
   logic                rfWriteEn_o;
   logic [4:0]          rfWriteAddr_o;
   logic [63:0]         rfWriteData_o;
   logic [addrSize:0]   rfWriteTag_o;
   logic                storeCommitValid_o;
   logic                storeCommitReady_i;
   logic                flush_o;
   logic [63:0]         redirectPc_o;
   logic                halted_o;
   logic [31:0]         commitCount_o;

   int n_tests = 0;
   int n_fail  = 0;

   rob_commit_unit #(
      .ROBsize      (ROBsize),
      .addrSize     (addrSize),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .robValid_i         (robValid_i),
      .head_i             (head_i),
      .commitReadData_i   (commitReadData_i),
      .updateHead_o       (updateHead_o),
      .rfWriteEn_o        (rfWriteEn_o),
      .rfWriteAddr_o      (rfWriteAddr_o),
      .rfWriteData_o      (rfWriteData_o),
      .rfWriteTag_o       (rfWriteTag_o),
      .storeCommitValid_o (storeCommitValid_o),
      .storeCommitReady_i (storeCommitReady_i),
      .flush_o            (flush_o),
      .redirectPc_o       (redirectPc_o),
      .halted_o           (halted_o),
      .commitCount_o      (commitCount_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [78:0] mk(input logic d, input logic rw, input logic st,
                                      input logic mp, input logic ex,
                                      input logic [4:0] dst, input logic [63:0] v);
      return {d, rw, st, mp, ex, dst, 5'd0, v};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      reset_i            = 1'b0;
      robValid_i         = 1'b0;
      storeCommitReady_i = 1'b0;
      commitReadData_i   = '0;
      head_i             = '0;
      tick();
      reset_i = 1'b1;
      #1;
   endtask

   initial begin
      do_reset();
      tick();
      check("rst_count",    64'(commitCount_o), 64'd0);
      check("rst_redirect", redirectPc_o, 64'd0);
      check("rst_halted",   64'(halted_o), 64'd0);
      check("rst_flush",    64'(flush_o), 64'd0);
      check("rst_upd",      64'(updateHead_o), 64'd0);
      check("rst_stv",      64'(storeCommitValid_o), 64'd0);

      // Reset in the middle of a store handshake
      robValid_i       = 1'b1;
      head_i           = 5'd1;
      commitReadData_i = mk(1, 0, 1, 0, 0, 5'd0, 64'hAA);
      #1;
      check("sw_stv_first", 64'(storeCommitValid_o), 64'd1);
      tick();
      check("sw_stv_wait", 64'(storeCommitValid_o), 64'd1);
      check("sw_upd_wait", 64'(updateHead_o), 64'd0);
      reset_i    = 1'b0;
      robValid_i = 1'b0;
      #1;
      check("sw_upd_inrst", 64'(updateHead_o), 64'd0);
      tick();
      reset_i = 1'b1;
      #1;
      check("sw_stv_after", 64'(storeCommitValid_o), 64'd0);
      check("sw_count",     64'(commitCount_o), 64'd0);
      robValid_i       = 1'b1;
      commitReadData_i = mk(1, 1, 0, 0, 0, 5'd9, 64'h99);
      #1;
      check("sw_back_commit", 64'(updateHead_o), 64'd1);
      do_reset();

      // Four back-to-back ALU retires
      for (int i = 0; i < 4; i++) begin
         robValid_i       = 1'b1;
         head_i           = 5'(i + 1);
         commitReadData_i = mk(1, 1, 0, 0, 0, 5'(i + 1), 64'(16 + i));
         #1;
         check($sformatf("alu%0d_upd", i),  64'(updateHead_o), 64'd1);
         check($sformatf("alu%0d_we", i),   64'(rfWriteEn_o), 64'd1);
         check($sformatf("alu%0d_addr", i), 64'(rfWriteAddr_o), 64'(i + 1));
         check($sformatf("alu%0d_data", i), rfWriteData_o, 64'(16 + i));
         check($sformatf("alu%0d_tag", i),  64'(rfWriteTag_o), 64'(i + 1));
         tick();
      end
      robValid_i = 1'b0;
      #1;
      check("alu_count",    64'(commitCount_o), 64'd4);
      check("alu_upd_idle", 64'(updateHead_o), 64'd0);

      // Head not done for five cycles
      robValid_i       = 1'b1;
      head_i           = 5'd5;
      commitReadData_i = mk(0, 1, 0, 0, 0, 5'd7, 64'h77);
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("nd%0d_upd", c), 64'(updateHead_o), 64'd0);
         tick();
      end
      commitReadData_i = mk(1, 0, 0, 0, 0, 5'd7, 64'h77);
      #1;
      check("nd_retire_upd", 64'(updateHead_o), 64'd1);
      check("nd_retire_we",  64'(rfWriteEn_o), 64'd0);
      tick();
      robValid_i = 1'b0;
      #1;
      check("nd_count", 64'(commitCount_o), 64'd5);

      // Store with ready withheld for three cycles
      robValid_i       = 1'b1;
      head_i           = 5'd6;
      commitReadData_i = mk(1, 0, 1, 0, 0, 5'd0, 64'h1234);
      for (int c = 0; c < 4; c++) begin
         storeCommitReady_i = (c == 3);
         #1;
         check($sformatf("st%0d_stv", c), 64'(storeCommitValid_o), 64'd1);
         check($sformatf("st%0d_upd", c), 64'(updateHead_o), 64'(c == 3));
         check($sformatf("st%0d_we", c),  64'(rfWriteEn_o), 64'd0);
         tick();
      end
      robValid_i         = 1'b0;
      storeCommitReady_i = 1'b0;
      #1;
      check("st_stv_after", 64'(storeCommitValid_o), 64'd0);
      check("st_count",     64'(commitCount_o), 64'd6);

      // Mispredict, flush, then resume with the entry behind it
      robValid_i       = 1'b1;
      head_i           = 5'd7;
      commitReadData_i = mk(1, 0, 0, 1, 0, 5'd0, 64'h400);
      #1;
      check("mp_upd",   64'(updateHead_o), 64'd1);
      check("mp_flush", 64'(flush_o), 64'd0);
      tick();
      head_i           = 5'd8;
      commitReadData_i = mk(1, 1, 0, 0, 0, 5'd5, 64'h55);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("fl%0d_flush", c), 64'(flush_o), 64'd1);
         check($sformatf("fl%0d_pc", c),    redirectPc_o, 64'h400);
         check($sformatf("fl%0d_upd", c),   64'(updateHead_o), 64'd0);
         tick();
      end
      check("mp_flush_end",  64'(flush_o), 64'd0);
      check("mp_resume_upd", 64'(updateHead_o), 64'd1);
      check("mp_resume_dat", rfWriteData_o, 64'h55);
      tick();
      robValid_i = 1'b0;
      #1;
      check("mp_count", 64'(commitCount_o), 64'd8);

      // Exception at commit count 7
      do_reset();
      robValid_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         head_i           = 5'(i + 1);
         commitReadData_i = mk(1, 1, 0, 0, 0, 5'd3, 64'(i));
         tick();
      end
      robValid_i = 1'b0;
      #1;
      check("ex_pre_count", 64'(commitCount_o), 64'd7);
      robValid_i       = 1'b1;
      head_i           = 5'd8;
      commitReadData_i = mk(1, 1, 0, 0, 1, 5'd4, 64'hDEAD);
      #1;
      check("ex_upd",        64'(updateHead_o), 64'd0);
      check("ex_halt_early", 64'(halted_o), 64'd0);
      tick();
      check("ex_halted", 64'(halted_o), 64'd1);
      check("ex_count",  64'(commitCount_o), 64'd7);
      commitReadData_i = mk(1, 1, 0, 0, 0, 5'd4, 64'hBEEF);
      #1;
      check("ex_no_retire", 64'(updateHead_o), 64'd0);
      tick();
      tick();
      check("ex_still_halted", 64'(halted_o), 64'd1);
      check("ex_count_hold",   64'(commitCount_o), 64'd7);
      do_reset();
      check("ex_cleared",  64'(halted_o), 64'd0);
      check("ex_count_rst", 64'(commitCount_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
